// File: rtl/mib_master_sched.sv
// Round-robin MIB bus master: arbitrates P_NUM_REQ requesters, serialises one 32-bit
// access as 16-bit words on the MIB bus, and returns read data or an ack-timeout status.
module mib_master_sched #(
    parameter int P_NUM_REQ              = 2,
    parameter int P_MIB_ACK_TIMEOUT_CLKS = 32,
    parameter int P_TURNAROUND_CLKS      = 2
) (
    input  logic                      i_sysclk,
    input  logic                      i_srst,
    input  logic [P_NUM_REQ-1:0]      i_req_valid,
    input  logic [P_NUM_REQ-1:0]      i_req_rd_wr_n,
    input  logic [32*P_NUM_REQ-1:0]   i_req_addr,
    input  logic [32*P_NUM_REQ-1:0]   i_req_wdata,
    output logic [P_NUM_REQ-1:0]      o_req_ready,
    output logic [P_NUM_REQ-1:0]      o_rsp_valid,
    output logic [31:0]               o_rsp_rdata,
    output logic                      o_rsp_timeout,
    output logic                      o_mib_start,
    output logic                      o_mib_rd_wr_n,
    input  logic                      i_mib_slave_ack,
    output logic [15:0]               o_mib_dabus,
    output logic                      o_mib_dabus_oe,
    input  logic [15:0]               i_mib_dabus,
    output logic                      o_busy
);

    localparam int PW = (P_NUM_REQ > 1) ? $clog2(P_NUM_REQ) : 1;
    localparam int TW = $clog2(P_MIB_ACK_TIMEOUT_CLKS + 1);
    localparam int AW = $clog2(P_TURNAROUND_CLKS + 2);

    // IDLE grant | ADDR_HI/LO address words | WR_HI/LO write words | WAIT_ACK slave ack
    // RD_LO second read word | RESP completion pulse | TURNAROUND bus idle gap
    typedef enum logic [3:0] {
        S_IDLE,
        S_ADDR_HI,
        S_ADDR_LO,
        S_WR_HI,
        S_WR_LO,
        S_WAIT_ACK,
        S_RD_LO,
        S_RESP,
        S_TURNAROUND
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [PW-1:0]   owner_q, owner_d;
    logic            rd_q, rd_d;
    logic [31:0]     addr_q, addr_d;
    logic [31:0]     wdata_q, wdata_d;
    logic [TW-1:0]   to_cnt_q, to_cnt_d;
    logic [AW-1:0]   ta_cnt_q, ta_cnt_d;
    logic [15:0]     cap_hi_q, cap_hi_d;
    logic [31:0]     rsp_rdata_q, rsp_rdata_d;
    logic            rsp_timeout_q, rsp_timeout_d;

    logic            gnt_found;
    logic [PW-1:0]   gnt_idx;
    logic [PW:0]     scan;
    logic [PW-1:0]   cand;

    // First valid requester at or above the pointer, wrapping around.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        scan      = '0;
        cand      = '0;
        for (int k = 0; k < P_NUM_REQ; k++) begin
            scan = {1'b0, ptr_q} + (PW+1)'(k);
            if (scan >= (PW+1)'(P_NUM_REQ))
                scan = scan - (PW+1)'(P_NUM_REQ);
            cand = scan[PW-1:0];
            if (!gnt_found && i_req_valid[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

    always_ff @(posedge i_sysclk or posedge i_srst) begin
        if (i_srst) begin
            state_q       <= S_IDLE;
            ptr_q         <= '0;
            owner_q       <= '0;
            rd_q          <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            to_cnt_q      <= '0;
            ta_cnt_q      <= '0;
            cap_hi_q      <= '0;
            rsp_rdata_q   <= '0;
            rsp_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            owner_q       <= owner_d;
            rd_q          <= rd_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            to_cnt_q      <= to_cnt_d;
            ta_cnt_q      <= ta_cnt_d;
            cap_hi_q      <= cap_hi_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        owner_d       = owner_q;
        rd_d          = rd_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        to_cnt_d      = '0;
        ta_cnt_d      = ta_cnt_q;
        cap_hi_d      = cap_hi_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_timeout_d = rsp_timeout_q;
        case (state_q)
            S_IDLE: begin
                if (gnt_found) begin
                    owner_d = gnt_idx;
                    rd_d    = i_req_rd_wr_n[gnt_idx];
                    addr_d  = i_req_addr[32*gnt_idx +: 32];
                    wdata_d = i_req_wdata[32*gnt_idx +: 32];
                    ptr_d   = (gnt_idx == PW'(P_NUM_REQ - 1)) ? '0 : gnt_idx + PW'(1);
                    state_d = S_ADDR_HI;
                end
            end
            S_ADDR_HI: state_d = S_ADDR_LO;
            S_ADDR_LO: state_d = rd_q ? S_WAIT_ACK : S_WR_HI;
            S_WR_HI:   state_d = S_WR_LO;
            S_WR_LO:   state_d = S_WAIT_ACK;
            S_WAIT_ACK: begin
                to_cnt_d = to_cnt_q + TW'(1);
                // An ack on the expiry cycle takes priority over the timeout.
                if (i_mib_slave_ack) begin
                    if (rd_q) begin
                        cap_hi_d = i_mib_dabus;
                        state_d  = S_RD_LO;
                    end else begin
                        rsp_rdata_d   = '0;
                        rsp_timeout_d = 1'b0;
                        state_d       = S_RESP;
                    end
                end else if (to_cnt_q == TW'(P_MIB_ACK_TIMEOUT_CLKS - 1)) begin
                    rsp_rdata_d   = '0;
                    rsp_timeout_d = 1'b1;
                    state_d       = S_RESP;
                end
            end
            S_RD_LO: begin
                rsp_rdata_d   = {cap_hi_q, i_mib_dabus};
                rsp_timeout_d = 1'b0;
                state_d       = S_RESP;
            end
            S_RESP: begin
                if (P_TURNAROUND_CLKS == 0) begin
                    state_d = S_IDLE;
                end else begin
                    ta_cnt_d = AW'(P_TURNAROUND_CLKS - 1);
                    state_d  = S_TURNAROUND;
                end
            end
            S_TURNAROUND: begin
                if (ta_cnt_q == '0)
                    state_d = S_IDLE;
                else
                    ta_cnt_d = ta_cnt_q - AW'(1);
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        o_req_ready    = '0;
        o_rsp_valid    = '0;
        o_mib_start    = 1'b0;
        o_mib_rd_wr_n  = 1'b1;
        o_mib_dabus    = '0;
        o_mib_dabus_oe = 1'b0;
        o_busy         = (state_q != S_IDLE);
        case (state_q)
            S_IDLE: begin
                // Grant is combinational on valid, so hold it off while reset is applied.
                if (gnt_found && !i_srst)
                    o_req_ready[gnt_idx] = 1'b1;
            end
            S_ADDR_HI: begin
                o_mib_start    = 1'b1;
                o_mib_rd_wr_n  = rd_q;
                o_mib_dabus_oe = 1'b1;
                o_mib_dabus    = addr_q[31:16];
            end
            S_ADDR_LO: begin
                o_mib_rd_wr_n  = rd_q;
                o_mib_dabus_oe = 1'b1;
                o_mib_dabus    = addr_q[15:0];
            end
            S_WR_HI: begin
                o_mib_rd_wr_n  = rd_q;
                o_mib_dabus_oe = 1'b1;
                o_mib_dabus    = wdata_q[31:16];
            end
            S_WR_LO: begin
                o_mib_rd_wr_n  = rd_q;
                o_mib_dabus_oe = 1'b1;
                o_mib_dabus    = wdata_q[15:0];
            end
            S_WAIT_ACK, S_RD_LO: o_mib_rd_wr_n = rd_q;
            S_RESP:              o_rsp_valid[owner_q] = 1'b1;
            default: ;
        endcase
    end

    assign o_rsp_rdata   = rsp_rdata_q;
    assign o_rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_mib_master_sched.sv
// Directed bench for mib_master_sched: acts as requesters and MIB slave, predicts each
// response into a scoreboard queue at grant time and compares when the DUT responds.
module tb_mib_master_sched;

    localparam int N  = 2;
    localparam int TO = 32;
    localparam int TA = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_rd;
    logic [32*N-1:0]   req_addr;
    logic [32*N-1:0]   req_wdata;
    logic [N-1:0]      req_ready;
    logic [N-1:0]      rsp_valid;
    logic [31:0]       rsp_rdata;
    logic              rsp_timeout;
    logic              mib_start;
    logic              mib_rd_wr_n;
    logic              mib_ack;
    logic [15:0]       mib_dout;
    logic              mib_oe;
    logic [15:0]       mib_din;
    logic              busy;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          r;
        logic [31:0] rdata;
        logic        to;
        int          lat;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    mib_master_sched #(
        .P_NUM_REQ(N), .P_MIB_ACK_TIMEOUT_CLKS(TO), .P_TURNAROUND_CLKS(TA)
    ) dut (
        .i_sysclk(clk), .i_srst(rst),
        .i_req_valid(req_valid), .i_req_rd_wr_n(req_rd),
        .i_req_addr(req_addr), .i_req_wdata(req_wdata),
        .o_req_ready(req_ready), .o_rsp_valid(rsp_valid),
        .o_rsp_rdata(rsp_rdata), .o_rsp_timeout(rsp_timeout),
        .o_mib_start(mib_start), .o_mib_rd_wr_n(mib_rd_wr_n),
        .i_mib_slave_ack(mib_ack), .o_mib_dabus(mib_dout),
        .o_mib_dabus_oe(mib_oe), .i_mib_dabus(mib_din), .o_busy(busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_grant(input int r, output bit got);
        got = 1'b0;
        for (int t = 0; t < 40; t++) begin
            if (req_ready != '0) begin
                got = 1'b1;
                break;
            end
            step();
        end
        chk("grant_seen", 32'(got), 32'd1);
        chk("grant_vec", 32'(req_ready), 32'(1) << r);
        chk("grant_idle", 32'(busy), 32'd0);
    endtask

    // One full transaction from requester r; ack_cyc is the WAIT_ACK cycle (1-based) of the ack, 0 = none.
    task automatic txn(input int r, input logic rd, input logic [31:0] addr,
                       input logic [31:0] wdata, input int ack_cyc,
                       input logic [15:0] dhi, input logic [15:0] dlo, input bit keep);
        exp_t e;
        exp_t p;
        bit   got;
        bit   rsp_seen;
        int   wf;
        int   k;
        req_valid[r]          = 1'b1;
        req_rd[r]             = rd;
        req_addr[32*r +: 32]  = addr;
        req_wdata[32*r +: 32] = wdata;
        #1;
        wait_grant(r, got);
        if (!got) return;
        wf      = rd ? 3 : 5;
        e.r     = r;
        e.to    = (ack_cyc == 0) || (ack_cyc > TO);
        e.rdata = (rd && !e.to) ? {dhi, dlo} : 32'h0;
        e.lat   = e.to ? wf + TO : wf + ack_cyc + (rd ? 1 : 0);
        sb.push_back(e);
        rsp_seen = 1'b0;
        k = 0;
        for (int c = 1; c <= 80; c++) begin
            step();
            k = c;
            mib_ack = 1'b0;
            mib_din = 16'h0;
            chk("ready_onehot", 32'($countones(req_ready)) <= 32'd1 ? 32'd1 : 32'd0, 32'd1);
            if (rsp_valid != '0) begin
                rsp_seen = 1'b1;
                break;
            end
            if (c == 1) begin
                chk("ahi_start", 32'(mib_start), 32'd1);
                chk("ahi_oe", 32'(mib_oe), 32'd1);
                chk("ahi_dir", 32'(mib_rd_wr_n), 32'(rd));
                chk("ahi_bus", 32'(mib_dout), 32'(addr[31:16]));
                if (!keep) req_valid[r] = 1'b0;
            end else if (c == 2) begin
                chk("alo_start", 32'(mib_start), 32'd0);
                chk("alo_oe", 32'(mib_oe), 32'd1);
                chk("alo_bus", 32'(mib_dout), 32'(addr[15:0]));
            end else if (!rd && c == 3) begin
                chk("whi_oe", 32'(mib_oe), 32'd1);
                chk("whi_bus", 32'(mib_dout), 32'(wdata[31:16]));
            end else if (!rd && c == 4) begin
                chk("wlo_oe", 32'(mib_oe), 32'd1);
                chk("wlo_bus", 32'(mib_dout), 32'(wdata[15:0]));
            end
            if (c >= wf) begin
                chk("wait_oe", 32'(mib_oe), 32'd0);
                chk("wait_start", 32'(mib_start), 32'd0);
            end
            // Spurious acks during the address/data phase must be ignored.
            if (c < wf) begin
                mib_ack = 1'b1;
                mib_din = 16'hDEAD;
            end
            if (ack_cyc != 0 && c == wf - 1 + ack_cyc) begin
                mib_ack = 1'b1;
                mib_din = dhi;
            end
            if (rd && ack_cyc != 0 && ack_cyc <= TO && c == wf + ack_cyc) begin
                mib_ack = 1'b1;
                mib_din = dlo;
            end
        end
        chk("rsp_seen", 32'(rsp_seen), 32'd1);
        if (!rsp_seen || sb.size() == 0) return;
        p = sb.pop_front();
        chk("rsp_vec", 32'(rsp_valid), 32'(1) << p.r);
        chk("rsp_rdata", rsp_rdata, p.rdata);
        chk("rsp_timeout", 32'(rsp_timeout), 32'(p.to));
        chk("rsp_latency", 32'(k), 32'(p.lat));
        chk("rsp_oe", 32'(mib_oe), 32'd0);
        for (int t = 0; t < TA; t++) begin
            mib_ack = 1'b1;
            step();
            chk("ta_busy", 32'(busy), 32'd1);
            chk("ta_oe", 32'(mib_oe), 32'd0);
            chk("ta_rsp", 32'(rsp_valid), 32'd0);
            chk("ta_hold", rsp_rdata, p.rdata);
        end
        mib_ack = 1'b0;
    endtask

    initial begin
        bit got;
        rst       = 1'b1;
        req_valid = '0;
        req_rd    = '0;
        req_addr  = '0;
        req_wdata = '0;
        mib_ack   = 1'b0;
        mib_din   = '0;
        req_valid[0] = 1'b1;
        step();
        step();
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_rsp", 32'(rsp_valid), 32'd0);
        chk("rst_start", 32'(mib_start), 32'd0);
        chk("rst_dir", 32'(mib_rd_wr_n), 32'd1);
        chk("rst_oe", 32'(mib_oe), 32'd0);
        chk("rst_bus", 32'(mib_dout), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rdata", rsp_rdata, 32'd0);
        chk("rst_to", 32'(rsp_timeout), 32'd0);
        req_valid = '0;
        rst = 1'b0;
        step();

        txn(0, 1'b0, 32'h1000_0004, 32'hCAFE_F00D, 3, 16'h0, 16'h0, 1'b0);
        txn(1, 1'b1, 32'h2000_0010, 32'h0, 1, 16'h1234, 16'h5678, 1'b0);
        txn(0, 1'b0, 32'h3000_0020, 32'h1111_2222, 0, 16'h0, 16'h0, 1'b0);
        txn(1, 1'b1, 32'h4000_0030, 32'h0, TO, 16'hA5A5, 16'h5A5A, 1'b0);
        txn(1, 1'b1, 32'h4000_0034, 32'h0, 0, 16'h0, 16'h0, 1'b0);

        // Round-robin with both requesters held valid (pointer is 0 here).
        req_valid[1]        = 1'b1;
        req_rd[1]           = 1'b0;
        req_addr[63:32]     = 32'h5100_0000;
        req_wdata[63:32]    = 32'h0101_0101;
        txn(0, 1'b0, 32'h5000_0000, 32'h0000_0001, 1, 16'h0, 16'h0, 1'b1);
        txn(1, 1'b0, 32'h5100_0000, 32'h0101_0101, 1, 16'h0, 16'h0, 1'b1);
        txn(0, 1'b1, 32'h5000_0008, 32'h0, 2, 16'hBEEF, 16'h0042, 1'b0);
        txn(1, 1'b1, 32'h5100_0008, 32'h0, 1, 16'hFACE, 16'hB00C, 1'b0);

        // Reset during WR_HI of a req0 write (pointer then 1).
        req_valid[0]    = 1'b1;
        req_rd[0]       = 1'b0;
        req_addr[31:0]  = 32'h6000_0000;
        req_wdata[31:0] = 32'h7777_8888;
        #1;
        wait_grant(0, got);
        step();
        req_valid[0] = 1'b0;
        step();
        step();
        chk("pre_rst_oe", 32'(mib_oe), 32'd1);
        rst = 1'b1;
        #1;
        chk("arst_oe", 32'(mib_oe), 32'd0);
        chk("arst_start", 32'(mib_start), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        for (int t = 0; t < 2; t++) begin
            step();
            chk("arst_rsp", 32'(rsp_valid), 32'd0);
        end
        rst = 1'b0;
        for (int t = 0; t < 3; t++) begin
            step();
            chk("post_rst_rsp", 32'(rsp_valid), 32'd0);
            chk("post_rst_busy", 32'(busy), 32'd0);
        end
        req_valid[1]     = 1'b1;
        req_rd[1]        = 1'b1;
        req_addr[63:32]  = 32'h6100_0000;
        txn(0, 1'b1, 32'h6000_0004, 32'h0, 1, 16'h0BAD, 16'hCAFE, 1'b0);
        txn(1, 1'b1, 32'h6100_0000, 32'h0, 2, 16'h1357, 16'h2468, 1'b0);

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
